// File: rtl/bsg_downstream_pkg.sv
// Shared types and constants for the downstream buffer read and write sides.
package bsg_downstream_pkg;

  localparam int ADDR_W    = 6;
  localparam int PTR_W     = ADDR_W + 1;
  localparam int TOKEN_BIT = 2;
  localparam int HALF_W    = 16;

  typedef enum logic [1:0] {
    S_LO  = 2'd0,
    S_HI  = 2'd1,
    S_OUT = 2'd2
  } state_t;

endpackage

// File: rtl/bsg_downstream_rd_ctrl.sv
// Drains 16-bit halfwords from the downstream buffer, pairs them into 32-bit
// core words and returns a credit token that toggles every 2**TOKEN_BIT reads.
module bsg_downstream_rd_ctrl #(
  parameter int ADDR_W    = bsg_downstream_pkg::ADDR_W,
  parameter int TOKEN_BIT = bsg_downstream_pkg::TOKEN_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wptr_t,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [15:0]       buf_data,
  output logic [31:0]       core_data_out,
  output logic              core_valid_out,
  input  logic              core_ready,
  output logic              io_token_out,
  output logic [ADDR_W:0]   rptr,
  output logic [ADDR_W:0]   occupancy
);
  import bsg_downstream_pkg::*;

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] MAX_OCC = {1'b1, {ADDR_W{1'b0}}};

  state_t        r_state, w_state_next;
  logic [PW-1:0] r_rptr, w_rptr_next, w_rptr_inc;
  logic [15:0]   r_data0, w_data0_next;
  logic [31:0]   r_data_out, w_data_out_next;
  logic          r_valid, w_valid_next;
  logic          r_token, w_token_next;
  logic          w_empty, w_advance;

  // Wrap bit included, so a full buffer is never mistaken for empty.
  assign w_empty    = (wptr_t == r_rptr);
  assign w_rptr_inc = r_rptr + PW'(1);

  assign buf_addr       = r_rptr[ADDR_W-1:0];
  assign occupancy      = wptr_t - r_rptr;
  assign rptr           = r_rptr;
  assign core_data_out  = r_data_out;
  assign core_valid_out = r_valid;
  assign io_token_out   = r_token;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LO;
      r_rptr     <= '0;
      r_data0    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_token    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rptr     <= w_rptr_next;
      r_data0    <= w_data0_next;
      r_data_out <= w_data_out_next;
      r_valid    <= w_valid_next;
      r_token    <= w_token_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_rptr_next     = r_rptr;
    w_data0_next    = r_data0;
    w_data_out_next = r_data_out;
    w_valid_next    = r_valid;
    w_token_next    = r_token;
    w_advance       = 1'b0;

    unique case (r_state)
      S_LO: begin
        if (!w_empty) begin
          w_data0_next = buf_data;
          w_advance    = 1'b1;
          w_state_next = S_HI;
        end
      end
      S_HI: begin
        if (!w_empty) begin
          w_data_out_next = {buf_data, r_data0};
          w_valid_next    = 1'b1;
          w_advance       = 1'b1;
          w_state_next    = S_OUT;
        end
      end
      S_OUT: begin
        // Handshake cycle performs no read; the next word starts from S_LO.
        if (core_ready) begin
          w_valid_next = 1'b0;
          w_state_next = S_LO;
        end
      end
      default: w_state_next = S_LO;
    endcase

    if (w_advance) begin
      w_rptr_next  = w_rptr_inc;
      w_token_next = w_rptr_inc[TOKEN_BIT];
    end
  end

  // Upstream overrun is a protocol error: flagged in simulation, never recovered.
  a_occupancy_bound : assert property (@(posedge clk) disable iff (rst)
    occupancy <= MAX_OCC);

  a_rptr_parity : assert property (@(posedge clk) disable iff (rst)
    r_rptr[0] == (r_state == S_HI));

endmodule

// File: tb/tb_bsg_downstream_rd_ctrl.sv
// Directed bench for bsg_downstream_rd_ctrl with a small buffer model.
module tb_bsg_downstream_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  wptr_t = '0;
  logic [5:0]  buf_addr;
  logic [15:0] buf_data;
  logic [31:0] core_data_out;
  logic        core_valid_out;
  logic        core_ready = 1'b0;
  logic        io_token_out;
  logic [6:0]  rptr;
  logic [6:0]  occupancy;

  logic [15:0] mem [64];
  logic [6:0]  exp_ptr;
  int checks   = 0;
  int failures = 0;

  assign buf_data = mem[buf_addr];

  always #5 clk = ~clk;

  bsg_downstream_rd_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .wptr_t         (wptr_t),
    .buf_addr       (buf_addr),
    .buf_data       (buf_data),
    .core_data_out  (core_data_out),
    .core_valid_out (core_valid_out),
    .core_ready     (core_ready),
    .io_token_out   (io_token_out),
    .rptr           (rptr),
    .occupancy      (occupancy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams until rptr reaches target with ready held high; every emitted
  // word is compared against the buffer model at the expected address.
  task automatic stream_to(input logic [6:0] target);
    int budget;
    logic [5:0] lo;
    logic [5:0] hi;
    budget = 0;
    wptr_t = target;
    core_ready = 1'b1;
    while (!(rptr == target && !core_valid_out) && budget < 400) begin
      tick();
      budget++;
      if (core_valid_out) begin
        lo = exp_ptr[5:0];
        hi = lo + 6'd1;
        check($sformatf("word_at_%0d", exp_ptr), core_data_out, {mem[hi], mem[lo]});
        exp_ptr = exp_ptr + 7'd2;
      end
    end
    check($sformatf("stream_in_budget_%0d", target), 32'(budget < 400), 32'd1);
    check($sformatf("stream_rptr_%0d", target), 32'(rptr), 32'(target));
    core_ready = 1'b0;
  endtask

  initial begin
    logic seen_valid;
    for (int i = 0; i < 64; i++) mem[i] = 16'hA500 + 16'(i);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;

    repeat (3) tick();
    check("rst_rptr",  32'(rptr), 32'd0);
    check("rst_valid", 32'(core_valid_out), 32'd0);
    check("rst_data",  core_data_out, 32'd0);
    check("rst_token", 32'(io_token_out), 32'd0);
    check("rst_occ",   32'(occupancy), 32'd0);
    check("rst_addr",  32'(buf_addr), 32'd0);

    // Empty and ready asserted outside S_OUT: nothing may move.
    rst = 1'b0;
    core_ready = 1'b1;
    tick();
    check("idle_rptr",  32'(rptr), 32'd0);
    check("idle_valid", 32'(core_valid_out), 32'd0);
    core_ready = 1'b0;

    wptr_t = 7'd2;
    tick();
    check("lo_rptr",  32'(rptr), 32'd1);
    check("lo_valid", 32'(core_valid_out), 32'd0);
    tick();
    check("first_valid", 32'(core_valid_out), 32'd1);
    check("first_data",  core_data_out, 32'h2222_1111);
    check("first_rptr",  32'(rptr), 32'd2);
    check("first_occ",   32'(occupancy), 32'd0);

    // Back-pressure for 5 cycles; new write data arrives mid-stall.
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d_valid", i), 32'(core_valid_out), 32'd1);
      check($sformatf("stall%0d_data", i),  core_data_out, 32'h2222_1111);
      check($sformatf("stall%0d_rptr", i),  32'(rptr), 32'd2);
      if (i == 1) wptr_t = 7'd3;
    end
    core_ready = 1'b1;
    tick();
    check("hs_valid",   32'(core_valid_out), 32'd0);
    check("hs_no_read", 32'(rptr), 32'd2);
    core_ready = 1'b0;

    // Only one halfword available: park in S_HI.
    tick();
    check("park_rptr", 32'(rptr), 32'd3);
    check("park_addr", 32'(buf_addr), 32'd3);
    tick();
    tick();
    check("parked_rptr",  32'(rptr), 32'd3);
    check("parked_valid", 32'(core_valid_out), 32'd0);
    wptr_t = 7'd4;
    tick();
    check("unpark_valid", 32'(core_valid_out), 32'd1);
    check("unpark_data",  core_data_out, 32'hA503_A502);
    check("unpark_rptr",  32'(rptr), 32'd4);
    check("token_at_4",   32'(io_token_out), 32'd1);
    core_ready = 1'b1;
    tick();
    check("unpark_hs", 32'(core_valid_out), 32'd0);
    core_ready = 1'b0;

    exp_ptr = 7'd4;
    stream_to(7'd8);
    check("token_at_8", 32'(io_token_out), 32'd0);
    stream_to(7'd64);
    check("token_at_64", 32'(io_token_out), 32'd0);
    stream_to(7'd126);
    check("addr_at_126",  32'(buf_addr), 32'd62);
    check("occ_at_126",   32'(occupancy), 32'd0);
    check("token_at_126", 32'(io_token_out), 32'd1);

    wptr_t = 7'd0;
    #1;
    check("occ_wrap", 32'(occupancy), 32'd2);
    stream_to(7'd0);
    check("wrap_occ",   32'(occupancy), 32'd0);
    check("wrap_token", 32'(io_token_out), 32'd0);
    check("wrap_addr",  32'(buf_addr), 32'd0);

    // Pending word in S_OUT, then an asynchronous reset mid-cycle.
    wptr_t = 7'd2;
    tick();
    tick();
    check("pend_valid", 32'(core_valid_out), 32'd1);
    check("pend_data",  core_data_out, 32'h2222_1111);
    #2;
    rst = 1'b1;
    wptr_t = 7'd0;
    #1;
    check("arst_valid", 32'(core_valid_out), 32'd0);
    check("arst_data",  core_data_out, 32'd0);
    check("arst_rptr",  32'(rptr), 32'd0);
    check("arst_token", 32'(io_token_out), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    core_ready = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (core_valid_out) seen_valid = 1'b1;
    end
    check("no_pending_word", 32'(seen_valid), 32'd0);
    check("post_rst_rptr",   32'(rptr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_downstream_rd_ctrl.md
BSG_DOWNSTREAM_RD_CTRL -- requirements
Module: bsg_downstream_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6: buffer address width, giving 64 x 16-bit entries.
REQ-002 SHALL have parameter TOKEN_BIT, default 2: pointer bit mirrored onto the token, one toggle per 4 halfwords.
REQ-003 SHALL have port clk, input, 1: single clock for all state.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port wptr_t, input, 7: write pointer already synchronized into clk, binary, with wrap bit.
REQ-006 SHALL have port buf_addr, output, 6: buffer read address, combinational, equal to rptr[5:0].
REQ-007 SHALL have port buf_data, input, 16: buffer read data, valid in the same cycle as buf_addr.
REQ-008 SHALL have port core_data_out, output, 32: assembled word {high half, low half}.
REQ-009 SHALL have port core_valid_out, output, 1: core_data_out valid.
REQ-010 SHALL have port core_ready, input, 1: core accepts the word.
REQ-011 SHALL have port io_token_out, output, 1: credit token level returned to the IO side.
REQ-012 SHALL have port rptr, output, 7: read pointer, registered.
REQ-013 SHALL have port occupancy, output, 7: (wptr_t - rptr) mod 128, combinational.

Function
REQ-014 SHALL treat the buffer as empty exactly when wptr_t == rptr, including the wrap bit.
REQ-015 SHALL implement an FSM with states S_LO, S_HI and S_OUT; reset state is S_LO.
REQ-016 In S_LO when not empty, SHALL capture buf_data into core_data0, increment rptr and go to S_HI; when empty, SHALL stay in S_LO with no change.
REQ-017 In S_HI when not empty, SHALL register core_data_out = {buf_data, core_data0}, set core_valid_out=1, increment rptr and go to S_OUT; when empty, SHALL wait in S_HI with core_data0 held.
REQ-018 In S_OUT, SHALL hold core_data_out and core_valid_out=1 stable until core_ready=1.
REQ-019 On the S_OUT handshake cycle, SHALL go to S_LO and clear core_valid_out on the next edge; no read occurs that cycle. Minimum period is 3 cycles per word.
REQ-020 core_ready while not in S_OUT SHALL be ignored.
REQ-021 Every rptr increment SHALL be mod 128, so 127 wraps to 0, and SHALL be registered together with io_token_out <= (rptr+1)[TOKEN_BIT]; io_token_out is otherwise held.
REQ-022 Changes to wptr_t while in S_OUT SHALL have no effect on state; buffered data is consumed after the return to S_LO.
REQ-023 An occupancy above 64 is an upstream protocol error; the block SHALL flag it with a simulation assertion only, with no functional recovery.
REQ-024 rptr[0] SHALL equal 0 in S_LO and S_OUT, and 1 in S_HI, at all times after reset.

Reset
REQ-025 rst SHALL asynchronously force: state=S_LO, rptr=0, core_data0=0, core_data_out=0, core_valid_out=0, io_token_out=0.
REQ-026 rst asserted mid-word, in S_HI or S_OUT, SHALL discard the partial or pending word; the IO side is required to reset its write pointer concurrently.
REQ-027 After rst deassertion, the first read SHALL occur no earlier than the first rising clk edge with wptr_t != 0.

Structure
REQ-028 The package bsg_downstream_pkg SHALL hold the state enum and the constants ADDR_W=6, PTR_W=ADDR_W+1 and TOKEN_BIT=2, shared with the write-side blocks.
REQ-029 The block SHALL be a single module with no sub-module; the pointer/occupancy logic stays inline at this size.

Verification
REQ-030 Reset then wptr_t=2, buf[0]=16'h1111, buf[1]=16'h2222 -> core_data_out=32'h2222_1111 with core_valid_out=1 two edges later, and rptr=2.
REQ-031 Valid word with core_ready=0 for 5 cycles, then 1 -> data and valid stable for all 5 cycles, valid low one edge after the handshake, state S_LO.
REQ-032 wptr_t=1 only -> core_data0 captured, FSM parked in S_HI; raising wptr_t to 2 -> word emitted with the correct low half.
REQ-033 Stream 8 halfwords with core_ready=1 -> io_token_out goes 0->1 when rptr reaches 4, and 1->0 when rptr reaches 8.
REQ-034 Preload rptr near wrap (stream to rptr=126), wptr_t=0 (i.e. 128) -> reads at buf_addr 62 and 63, rptr=0, empty, occupancy=0.
REQ-035 rst pulsed asynchronously while in S_OUT, mid-cycle -> all outputs at reset values immediately, pending word never handshaken.
